branch_resolve: RTL and testbench
=================================

# branch_resolve

Single-entry, registered branch resolution stage for the NPC execute path. It accepts one decoded control-transfer instruction per handshake, evaluates the branch condition using the team's 3-bit compare function code, and computes the actual next PC. It compares that PC against the fetch-stage prediction and presents redirect/link results to writeback and fetch through a valid/ready handshake. It also keeps running branch and mispredict counters for perf readout.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  kill the held entry and refuse new input this cycle.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  stage can accept.
- in_pc  in  32  instruction PC.
- in_imm  in  32  sign-extended immediate.
- in_rs1, in_rs2  in  32  operand values.
- in_fn  in  3  compare code: 000 eq, 001 ne, 010 ge (signed), 011 lt (signed), 101 ltu, 110 geu; 100 and 111 are illegal for branches.
- in_kind  in  2  00 conditional branch, 01 jal, 10 jalr, 11 reserved (treated as illegal).
- in_pred_pc  in  32  next PC fetch used.
- out_valid  out  1  result held.
- out_ready  in  1  downstream takes result.
- out_taken  out  1  transfer taken.
- out_next_pc  out  32  resolved next PC.
- out_link  out  32  in_pc+4, the rd value for jal/jalr.
- out_mispredict  out  1  out_next_pc != captured in_pred_pc.
- out_misalign  out  1  taken target with bits [1:0] != 0.
- out_illegal  out  1  illegal fn/kind.
- perf_branches  out  32  accepted entries, counting all kinds.
- perf_mispredicts  out  32  accepted entries with mispredict set.

## Operation
- Accept = in_valid & in_ready & ~flush. in_ready = ~out_valid | out_ready. Assert in_ready combinationally; it does not depend on in_valid.
- Condition, evaluated on the accept cycle. Do 32-bit signed compares on two's-complement values and unsigned compares on raw values.
  - eq: a==b.
  - ne: a!=b.
  - ge: a>=b signed.
  - lt: a<b signed.
  - ltu: a<b unsigned.
  - geu: a>=b unsigned.
- Taken per kind:
  - branch: taken = condition.
  - jal and jalr: taken = 1.
  - illegal: taken = 0, out_illegal = 1.
- Target per kind. All additions are modulo 2^32 and wrap silently.
  - branch and jal: target = in_pc+in_imm.
  - jalr: target = (in_rs1+in_imm) & ~1.
- next_pc = taken ? target : in_pc+4.
- out_misalign = taken & (next_pc[1:0] != 0). The entry still completes; the trap is raised downstream.
- out_mispredict = (next_pc != in_pred_pc). Compute it for illegal entries too.
- State: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on out_ready without accept.
  - FULL→FULL with new payload when out_ready and accept occur together.
- flush clears out_valid next edge, overriding any accept or handshake that cycle. Counters do not increment on a flush cycle.
- Counters increment on accept only and wrap at 2^32.

## Timing
- Latency 1: results appear the cycle after accept. Throughput is 1 per cycle while out_ready is held high.
- Payload outputs are stable while out_valid & ~out_ready.
- Reset (async assert, sync release): every output register goes to 0, including out_valid, all payload fields and both counters. in_ready reads 1 after reset.
- Reset mid-operation drops the held entry without a handshake.
- Simultaneous flush and rst: rst wins.

## Structure
- Shared package npc_pkg holds:
  - compare codes CMP_EQ/NE/GE/LT/LTU/GEU;
  - kind codes KIND_BR/JAL/JALR;
  - constant PC_STEP=4.
- One sub-module, branch_cond: purely combinational, taking a, b, fn and returning cond and illegal. Reuse it in later stages.
- The top level holds the handshake register, next-PC math and counters.

## Test plan
- Branch eq: rs1=rs2=5, pc=0x100, imm=0x20, pred=0x104 → out_taken=1, next_pc=0x120, mispredict=1, perf_mispredicts=1.
- lt vs ltu: rs1=0xFFFFFFFF, rs2=1. Expected results:
  - fn=011 → taken;
  - fn=101 → not taken, next_pc=pc+4.
- jalr: rs1=0x2003, imm=0, pc=0x80 → next_pc=0x2002, link=0x84, misalign=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, payload unchanged. Then pulse out_ready=1 → the next entry is accepted the same cycle.
- Illegal code fn=100 or kind=11 → taken=0, illegal=1, next_pc=pc+4.
- Flush and reset:
  - flush while FULL with accept offered → out_valid=0 next cycle, counters unchanged.
  - async rst mid-FULL → all outputs 0 before the next edge.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared NPC execute-path constants: compare codes, control-transfer kinds, payload layout.
// Imported by the branch resolution stage and its condition evaluator.
package npc_pkg;

  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_NE  = 3'b001;
  localparam logic [2:0] CMP_GE  = 3'b010;
  localparam logic [2:0] CMP_LT  = 3'b011;
  localparam logic [2:0] CMP_LTU = 3'b101;
  localparam logic [2:0] CMP_GEU = 3'b110;

  localparam logic [1:0] KIND_BR   = 2'b00;
  localparam logic [1:0] KIND_JAL  = 2'b01;
  localparam logic [1:0] KIND_JALR = 2'b10;
  localparam logic [1:0] KIND_RSV  = 2'b11;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } br_state_e;

  typedef struct packed {
    logic        taken;
    logic [31:0] next_pc;
    logic [31:0] link;
    logic        mispredict;
    logic        misalign;
    logic        illegal;
  } br_res_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator: cond and illegal-code flag from a, b, fn.
// Zero latency, no handshake; codes 100 and 111 report illegal with cond forced low.
module branch_cond
  import npc_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  fn_i,
  output logic        cond_o,
  output logic        illegal_o
);

  always_comb begin
    cond_o    = 1'b0;
    illegal_o = 1'b0;
    case (fn_i)
      CMP_EQ:  cond_o = (a_i == b_i);
      CMP_NE:  cond_o = (a_i != b_i);
      CMP_GE:  cond_o = ($signed(a_i) >= $signed(b_i));
      CMP_LT:  cond_o = ($signed(a_i) <  $signed(b_i));
      CMP_LTU: cond_o = (a_i <  b_i);
      CMP_GEU: cond_o = (a_i >= b_i);
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Registered branch resolution: taken/next-PC/link/mispredict one cycle after accept.
// Single entry; in_ready = ~out_valid | out_ready, payload held while stalled; flush drops the entry.
module branch_resolve
  import npc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [2:0]      in_fn,
  input  logic [1:0]      in_kind,
  input  logic [XLEN-1:0] in_pred_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_next_pc,
  output logic [XLEN-1:0] out_link,
  output logic            out_mispredict,
  output logic            out_misalign,
  output logic            out_illegal,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
);

  br_state_e   state_q, state_d;
  br_res_t     res_q, res_d;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;

  logic            cond, cond_illegal, accept;
  logic [XLEN-1:0] seq_pc, target;

  branch_cond u_cond (
    .a_i      (in_rs1),
    .b_i      (in_rs2),
    .fn_i     (in_fn),
    .cond_o   (cond),
    .illegal_o(cond_illegal)
  );

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready & ~flush;

  assign seq_pc = in_pc + PC_STEP;
  // jalr clears bit 0 of the register-relative target; bit 1 is left for the misalign check
  assign target = (in_kind == KIND_JALR) ? ((in_rs1 + in_imm) & ~32'd1) : (in_pc + in_imm);

  always_comb begin
    res_d         = '0;
    res_d.illegal = (in_kind == KIND_RSV) | ((in_kind == KIND_BR) & cond_illegal);
    res_d.taken   = ~res_d.illegal & ((in_kind == KIND_BR) ? cond : 1'b1);
    res_d.next_pc = res_d.taken ? target : seq_pc;
    res_d.link    = seq_pc;
    res_d.misalign   = res_d.taken & (res_d.next_pc[1:0] != 2'b00);
    res_d.mispredict = (res_d.next_pc != in_pred_pc);
  end

  always_comb begin
    state_d  = state_q;
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d  = ST_FULL;
      br_cnt_d = br_cnt_q + 32'd1;
      mp_cnt_d = mp_cnt_q + {31'd0, res_d.mispredict};
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      res_q    <= '0;
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
      if (accept) begin
        res_q <= res_d;
      end
    end
  end

  assign out_taken        = res_q.taken;
  assign out_next_pc      = res_q.next_pc;
  assign out_link         = res_q.link;
  assign out_mispredict   = res_q.mispredict;
  assign out_misalign     = res_q.misalign;
  assign out_illegal      = res_q.illegal;
  assign perf_branches    = br_cnt_q;
  assign perf_mispredicts = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: behavioural reference checked every cycle plus literal spot checks.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0, in_imm = '0, in_rs1 = '0, in_rs2 = '0, in_pred_pc = '0;
  logic [2:0]  in_fn = '0;
  logic [1:0]  in_kind = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_taken, out_mispredict, out_misalign, out_illegal;
  logic [31:0] out_next_pc, out_link, perf_branches, perf_mispredicts;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_fn(in_fn), .in_kind(in_kind), .in_pred_pc(in_pred_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_next_pc(out_next_pc), .out_link(out_link),
    .out_mispredict(out_mispredict), .out_misalign(out_misalign), .out_illegal(out_illegal),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  typedef struct packed {
    logic        taken;
    logic [31:0] next_pc;
    logic [31:0] link;
    logic        misp;
    logic        misal;
    logic        ill;
  } exp_t;

  // Reference outcome written straight from the instruction semantics.
  function automatic exp_t resolve(input logic [31:0] pc, imm, rs1, rs2, pred,
                                   input logic [2:0] fn, input logic [1:0] kind);
    exp_t e;
    int signed sa, sb;
    logic cond;
    bit bad_fn;
    sa = rs1;
    sb = rs2;
    bad_fn = (fn == 3'd4) || (fn == 3'd7);
    if (fn == 3'd0)      cond = (rs1 == rs2);
    else if (fn == 3'd1) cond = (rs1 != rs2);
    else if (fn == 3'd2) cond = (sa >= sb);
    else if (fn == 3'd3) cond = (sa < sb);
    else if (fn == 3'd5) cond = (rs1 < rs2);
    else if (fn == 3'd6) cond = (rs1 >= rs2);
    else                 cond = 1'b0;
    e.ill   = (kind == 2'd3) || (kind == 2'd0 && bad_fn);
    e.taken = e.ill ? 1'b0 : (kind == 2'd0 ? cond : 1'b1);
    e.link  = pc + 32'd4;
    if (!e.taken)        e.next_pc = pc + 32'd4;
    else if (kind == 2'd2) e.next_pc = (rs1 + imm) & 32'hFFFF_FFFE;
    else                 e.next_pc = pc + imm;
    e.misal = e.taken && (e.next_pc % 4 != 0);
    e.misp  = (e.next_pc != pred);
    return e;
  endfunction

  logic        m_valid;
  exp_t        m_res;
  logic [31:0] m_br, m_mp;
  exp_t        m_now;
  wire         m_in_ready = ~m_valid | out_ready;
  wire         m_acc = in_valid & m_in_ready & ~flush;
  assign m_now = resolve(in_pc, in_imm, in_rs1, in_rs2, in_pred_pc, in_fn, in_kind);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_res   <= '0;
      m_br    <= '0;
      m_mp    <= '0;
    end else begin
      if (m_acc) begin
        m_res <= m_now;
        m_br  <= m_br + 1;
        m_mp  <= m_mp + (m_now.misp ? 1 : 0);
      end
      if (flush)          m_valid <= 1'b0;
      else if (m_acc)     m_valid <= 1'b1;
      else if (out_ready) m_valid <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("mdl.out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("mdl.in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
      chk("mdl.perf_branches", perf_branches, m_br);
      chk("mdl.perf_mispredicts", perf_mispredicts, m_mp);
      if (m_valid) begin
        chk("mdl.taken", {31'd0, out_taken}, {31'd0, m_res.taken});
        chk("mdl.next_pc", out_next_pc, m_res.next_pc);
        chk("mdl.link", out_link, m_res.link);
        chk("mdl.mispredict", {31'd0, out_mispredict}, {31'd0, m_res.misp});
        chk("mdl.misalign", {31'd0, out_misalign}, {31'd0, m_res.misal});
        chk("mdl.illegal", {31'd0, out_illegal}, {31'd0, m_res.ill});
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, imm, rs1, rs2, pred,
                       input logic [2:0] fn, input logic [1:0] kind);
    in_pc = pc; in_imm = imm; in_rs1 = rs1; in_rs2 = rs2;
    in_pred_pc = pred; in_fn = fn; in_kind = kind; in_valid = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".taken"}, {31'd0, out_taken}, 32'd0);
    chk({tag, ".next_pc"}, out_next_pc, 32'd0);
    chk({tag, ".link"}, out_link, 32'd0);
    chk({tag, ".flags"}, {29'd0, out_mispredict, out_misalign, out_illegal}, 32'd0);
    chk({tag, ".perf_br"}, perf_branches, 32'd0);
    chk({tag, ".perf_mp"}, perf_mispredicts, 32'd0);
  endtask

  logic [31:0] snap_br, snap_mp;

  initial begin
    #12;
    chk_all_zero("reset");
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    // eq taken, prediction assumed fall-through
    drive(32'h100, 32'h20, 32'd5, 32'd5, 32'h104, 3'b000, 2'b00);
    step;
    chk("eq.taken", {31'd0, out_taken}, 32'd1);
    chk("eq.next_pc", out_next_pc, 32'h120);
    chk("eq.mispredict", {31'd0, out_mispredict}, 32'd1);
    chk("eq.perf_mp", perf_mispredicts, 32'd1);
    chk("eq.perf_br", perf_branches, 32'd1);

    // signed vs unsigned on -1 vs 1
    drive(32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'h240, 3'b011, 2'b00);
    step;
    chk("lt.taken", {31'd0, out_taken}, 32'd1);
    chk("lt.next_pc", out_next_pc, 32'h240);
    chk("lt.mispredict", {31'd0, out_mispredict}, 32'd0);
    drive(32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'h240, 3'b101, 2'b00);
    step;
    chk("ltu.taken", {31'd0, out_taken}, 32'd0);
    chk("ltu.next_pc", out_next_pc, 32'h204);
    chk("ltu.mispredict", {31'd0, out_mispredict}, 32'd1);

    // jalr drops bit 0 but keeps bit 1 -> misaligned
    drive(32'h80, 32'h0, 32'h2003, 32'h0, 32'h84, 3'b000, 2'b10);
    step;
    chk("jalr.next_pc", out_next_pc, 32'h2002);
    chk("jalr.link", out_link, 32'h84);
    chk("jalr.misalign", {31'd0, out_misalign}, 32'd1);

    // jal with negative offset wrapping to 0
    drive(32'h10, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h0, 3'b111, 2'b01);
    step;
    chk("jal.next_pc", out_next_pc, 32'h0);
    chk("jal.taken_ill", {30'd0, out_taken, out_illegal}, 32'd2);

    drive(32'h300, 32'h40, 32'd1, 32'd1, 32'h304, 3'b100, 2'b00);
    step;
    chk("ill_fn.flags", {30'd0, out_taken, out_illegal}, 32'd1);
    chk("ill_fn.next_pc", out_next_pc, 32'h304);
    drive(32'h400, 32'h40, 32'd1, 32'd1, 32'h500, 3'b000, 2'b11);
    step;
    chk("ill_kind.flags", {30'd0, out_taken, out_illegal}, 32'd1);
    chk("ill_kind.next_pc", out_next_pc, 32'h404);
    chk("ill_kind.mispredict", {31'd0, out_mispredict}, 32'd1);

    // backpressure: entry A held while B waits
    drive(32'h600, 32'h8, 32'd3, 32'd3, 32'h608, 3'b000, 2'b00);
    step;
    out_ready = 1'b0;
    drive(32'h700, 32'h10, 32'd1, 32'd2, 32'h704, 3'b001, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp.hold_next_pc", out_next_pc, 32'h608);
    end
    out_ready = 1'b1;
    #1 chk("bp.release_ready", {31'd0, in_ready}, 32'd1);
    step;
    chk("bp.next_entry", out_next_pc, 32'h710);

    // flush while full with a new entry offered
    snap_br = m_br;
    snap_mp = m_mp;
    flush = 1'b1;
    drive(32'h800, 32'h4, 32'd0, 32'd0, 32'h0, 3'b000, 2'b00);
    step;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush.out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush.perf_br", perf_branches, snap_br);
    chk("flush.perf_mp", perf_mispredicts, snap_mp);
    step;

    // back-to-back entries at full throughput
    for (int i = 0; i < 4; i++) begin
      drive(32'h1000 + 32'(i * 16), 32'(i * 4 + 2), 32'(i), 32'd2, 32'h1004 + 32'(i * 16),
            3'b010, 2'b00);
      step;
    end
    in_valid = 1'b0;
    step;

    // async reset while full
    drive(32'h900, 32'h10, 32'd7, 32'd7, 32'h0, 3'b000, 2'b00);
    step;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1 chk_all_zero("arst");
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    step;
    chk("post_rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst.out_valid", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
